// File: rtl/cache_types.sv
// rtl/cache_types.sv - shared types and constants for the set-associative cache
package cache_types;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        FILL      = 2'd2
    } cache_state_t;

    localparam int LINE_BITS = 256;

endpackage

// File: rtl/plru_tree.sv
// rtl/plru_tree.sv - tree pseudo-LRU next-state and victim computation for one set
module plru_tree #(
    parameter int num_ways = 4
) (
    input  logic [num_ways-2:0]         bits,
    input  logic [$clog2(num_ways)-1:0] way,
    output logic [num_ways-2:0]         next_bits,
    output logic [$clog2(num_ways)-1:0] victim
);

    localparam int lvls = $clog2(num_ways);

    int   pos;
    logic bit_sel;

    // Flip every node on the accessed way's path so it points at the other subtree
    always_comb begin
        next_bits = bits;
        for (int l = 0; l < lvls; l++) begin
            for (int p = 0; p < (1 << l); p++) begin
                if ((int'(way) >> (lvls - l)) == p) begin
                    next_bits[(1 << l) - 1 + p] = ~way[lvls - 1 - l];
                end
            end
        end
    end

    // Walk from the root following the node bits; a 0 bit descends left
    always_comb begin
        pos     = 0;
        bit_sel = 1'b0;
        for (int l = 0; l < lvls; l++) begin
            bit_sel = 1'b0;
            for (int p = 0; p < (1 << l); p++) begin
                if (p == pos) begin
                    bit_sel = bits[(1 << l) - 1 + p];
                end
            end
            pos = pos * 2 + int'(bit_sel);
        end
        victim = pos[lvls-1:0];
    end

endmodule

// File: rtl/cache_nway.sv
// rtl/cache_nway.sv - N-way set-associative write-back write-allocate cache with PLRU
module cache_nway
    import cache_types::*;
#(
    parameter int s_offset = 5,
    parameter int s_index  = 3,
    parameter int num_ways = 4,
    parameter int s_tag    = 32 - s_offset - s_index
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [31:0]          mem_address,
    input  logic                 mem_read,
    input  logic                 mem_write,
    input  logic [3:0]           mem_byte_enable,
    input  logic [31:0]          mem_wdata,
    output logic [31:0]          mem_rdata,
    output logic                 mem_resp,
    output logic                 stall,
    output logic [31:0]          pmem_address,
    output logic                 pmem_read,
    output logic                 pmem_write,
    output logic [LINE_BITS-1:0] pmem_wdata,
    input  logic [LINE_BITS-1:0] pmem_rdata,
    input  logic                 pmem_resp,
    output logic [31:0]          hit_count,
    output logic [31:0]          miss_count
);

    localparam int num_sets = 2 ** s_index;
    localparam int way_bits = $clog2(num_ways);

    logic [num_ways-1:0]  valid_q [num_sets];
    logic [num_ways-1:0]  dirty_q [num_sets];
    logic [num_ways-2:0]  plru_q  [num_sets];
    logic [s_tag-1:0]     tag_q   [num_sets][num_ways];
    logic [LINE_BITS-1:0] data_q  [num_sets][num_ways];

    cache_state_t        state;
    logic [way_bits-1:0] victim_q;
    logic [s_tag-1:0]    req_tag_q;
    logic [s_index-1:0]  idx_q;
    logic                after_fill;

    logic                req;
    logic [s_index-1:0]  idx;
    logic [s_tag-1:0]    req_tag;
    logic [7:0]          word_base;
    logic                hit;
    logic                hit_ok;
    logic [way_bits-1:0] hit_way;
    logic                has_invalid;
    logic [way_bits-1:0] inv_way;
    logic [way_bits-1:0] alloc_way;
    logic [way_bits-1:0] plru_victim;
    logic [num_ways-2:0] plru_next;
    logic [31:0]         hit_word;
    logic [31:0]         merged;
    logic                unused_addr_bits;

    assign req              = mem_read | mem_write;
    assign idx              = mem_address[s_offset +: s_index];
    assign req_tag          = mem_address[31 -: s_tag];
    assign word_base        = {mem_address[4:2], 5'd0};
    assign unused_addr_bits = ^mem_address[1:0];

    // Tag compare across all ways of the addressed set
    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        for (int w = 0; w < num_ways; w++) begin
            if (valid_q[idx][w] && tag_q[idx][w] == req_tag) begin
                hit     = 1'b1;
                hit_way = way_bits'(w);
            end
        end
    end

    // Lowest-numbered invalid way wins over the PLRU choice
    always_comb begin
        has_invalid = 1'b0;
        inv_way     = '0;
        for (int w = num_ways - 1; w >= 0; w--) begin
            if (!valid_q[idx][w]) begin
                has_invalid = 1'b1;
                inv_way     = way_bits'(w);
            end
        end
    end

    plru_tree #(.num_ways(num_ways)) u_plru (
        .bits      (plru_q[idx]),
        .way       (hit_way),
        .next_bits (plru_next),
        .victim    (plru_victim)
    );

    assign alloc_way = has_invalid ? inv_way : plru_victim;
    assign hit_ok    = (state == IDLE) && req && hit;
    assign hit_word  = data_q[idx][hit_way][word_base +: 32];

    // Byte-lane merge of the CPU write into the hit word
    always_comb begin
        merged = hit_word;
        for (int b = 0; b < 4; b++) begin
            if (mem_byte_enable[b]) begin
                merged[b*8 +: 8] = mem_wdata[b*8 +: 8];
            end
        end
    end

    // CPU-side response decode
    always_comb begin
        mem_resp  = hit_ok;
        mem_rdata = hit_ok ? hit_word : 32'd0;
        stall     = req && !hit_ok;
    end

    // Physical-memory side decode from the current state
    always_comb begin
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_address = 32'd0;
        pmem_wdata   = '0;
        case (state)
            WRITEBACK: begin
                pmem_write   = 1'b1;
                pmem_address = {tag_q[idx_q][victim_q], idx_q, {s_offset{1'b0}}};
                pmem_wdata   = data_q[idx_q][victim_q];
            end
            FILL: begin
                pmem_read    = 1'b1;
                pmem_address = {req_tag_q, idx_q, {s_offset{1'b0}}};
            end
            default: ;
        endcase
    end

    // Line data and tags: write hits merge a word, fills replace the victim line
    always_ff @(posedge clk) begin
        if (hit_ok && mem_write) begin
            data_q[idx][hit_way][word_base +: 32] <= merged;
        end
        if (state == FILL && pmem_resp) begin
            data_q[idx_q][victim_q] <= pmem_rdata;
            tag_q[idx_q][victim_q]  <= req_tag_q;
        end
    end

    // Controller FSM, valid/dirty/PLRU state and saturating counters
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            victim_q   <= '0;
            req_tag_q  <= '0;
            idx_q      <= '0;
            after_fill <= 1'b0;
            hit_count  <= 32'd0;
            miss_count <= 32'd0;
            for (int s = 0; s < num_sets; s++) begin
                valid_q[s] <= '0;
                dirty_q[s] <= '0;
                plru_q[s]  <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (req && hit) begin
                        plru_q[idx] <= plru_next;
                        if (mem_write) begin
                            dirty_q[idx][hit_way] <= 1'b1;
                        end
                        if (after_fill) begin
                            after_fill <= 1'b0;
                        end else if (hit_count != 32'hFFFF_FFFF) begin
                            hit_count <= hit_count + 32'd1;
                        end
                    end else if (req) begin
                        victim_q  <= alloc_way;
                        req_tag_q <= req_tag;
                        idx_q     <= idx;
                        if (miss_count != 32'hFFFF_FFFF) begin
                            miss_count <= miss_count + 32'd1;
                        end
                        if (valid_q[idx][alloc_way] && dirty_q[idx][alloc_way]) begin
                            state <= WRITEBACK;
                        end else begin
                            state <= FILL;
                        end
                    end
                end
                WRITEBACK: begin
                    if (pmem_resp) begin
                        state <= FILL;
                    end
                end
                FILL: begin
                    if (pmem_resp) begin
                        valid_q[idx_q][victim_q] <= 1'b1;
                        dirty_q[idx_q][victim_q] <= 1'b0;
                        after_fill               <= 1'b1;
                        state                    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cache_nway.sv
// tb/tb_cache_nway.sv - self-checking bench for cache_nway
module tb_cache_nway;

    logic         clk;
    logic         reset;
    logic [31:0]  mem_address;
    logic         mem_read;
    logic         mem_write;
    logic [3:0]   mem_byte_enable;
    logic [31:0]  mem_wdata;
    logic [31:0]  mem_rdata;
    logic         mem_resp;
    logic         stall;
    logic [31:0]  pmem_address;
    logic         pmem_read;
    logic         pmem_write;
    logic [255:0] pmem_wdata;
    logic [255:0] pmem_rdata;
    logic         pmem_resp;
    logic [31:0]  hit_count;
    logic [31:0]  miss_count;

    logic [31:0]  m2_address;
    logic         m2_read;
    logic         m2_write;
    logic [3:0]   m2_be;
    logic [31:0]  m2_wdata;
    logic [31:0]  m2_rdata;
    logic         m2_resp;
    logic         m2_stall;
    logic [31:0]  p2_address;
    logic         p2_read;
    logic         p2_write;
    logic [255:0] p2_wdata;
    logic [255:0] p2_rdata;
    logic         p2_resp;
    logic [31:0]  m2_hits;
    logic [31:0]  m2_misses;

    int n_vec = 0;
    int n_miscomp = 0;
    int d1_delay = 3;
    int d1_cnt = 0;

    logic [255:0] pmem_mem  [logic [31:0]];
    logic [31:0]  ref_words [logic [31:0]];

    cache_nway dut (
        .clk(clk), .reset(reset), .mem_address(mem_address), .mem_read(mem_read),
        .mem_write(mem_write), .mem_byte_enable(mem_byte_enable), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_resp(mem_resp), .stall(stall),
        .pmem_address(pmem_address), .pmem_read(pmem_read), .pmem_write(pmem_write),
        .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp),
        .hit_count(hit_count), .miss_count(miss_count)
    );

    cache_nway #(.num_ways(2)) dut2 (
        .clk(clk), .reset(reset), .mem_address(m2_address), .mem_read(m2_read),
        .mem_write(m2_write), .mem_byte_enable(m2_be), .mem_wdata(m2_wdata),
        .mem_rdata(m2_rdata), .mem_resp(m2_resp), .stall(m2_stall),
        .pmem_address(p2_address), .pmem_read(p2_read), .pmem_write(p2_write),
        .pmem_wdata(p2_wdata), .pmem_rdata(p2_rdata), .pmem_resp(p2_resp),
        .hit_count(m2_hits), .miss_count(m2_misses)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [255:0] pat_line(input logic [31:0] la);
        logic [255:0] l;
        for (int i = 0; i < 8; i++) l[i*32 +: 32] = (la + 32'(4 * i)) ^ 32'h5A5A_0000;
        return l;
    endfunction

    function automatic logic [255:0] get_line(input logic [31:0] la);
        if (pmem_mem.exists(la)) return pmem_mem[la];
        return pat_line(la);
    endfunction

    function automatic logic [31:0] ref_read(input logic [31:0] a);
        logic [255:0] l;
        if (ref_words.exists(a)) return ref_words[a];
        l = get_line({a[31:5], 5'd0});
        return l[a[4:2]*32 +: 32];
    endfunction

    // Physical memory model for the 4-way instance with programmable latency
    always @(negedge clk) begin
        if (pmem_resp) begin
            pmem_resp = 1'b0;
            d1_cnt = 0;
        end else if (pmem_read || pmem_write) begin
            d1_cnt++;
            if (d1_cnt >= d1_delay) begin
                if (pmem_write) pmem_mem[pmem_address] = pmem_wdata;
                else pmem_rdata = get_line(pmem_address);
                pmem_resp = 1'b1;
            end
        end else begin
            d1_cnt = 0;
        end
    end

    // Physical memory model for the 2-way instance, one-cycle latency, pattern data
    always @(negedge clk) begin
        if (p2_resp) p2_resp = 1'b0;
        else if (p2_read || p2_write) begin
            p2_rdata = pat_line(p2_address);
            p2_resp = 1'b1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miscomp++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic access(input bit wr, input bit both, input logic [31:0] addr,
                          input logic [3:0] be, input logic [31:0] wd,
                          output logic [31:0] rd, output int cyc);
        @(negedge clk);
        mem_address = addr;
        mem_write = wr;
        mem_read = !wr || both;
        mem_byte_enable = be;
        mem_wdata = wd;
        cyc = 0;
        #1;
        while (!mem_resp && cyc < 200) begin
            @(negedge clk);
            #1;
            cyc++;
        end
        rd = mem_rdata;
        if (!mem_resp) begin
            check("access_timeout", 32'(cyc), 32'd0);
            cyc = -1;
        end
        @(posedge clk);
        #1;
        mem_read = 1'b0;
        mem_write = 1'b0;
    endtask

    task automatic wait_for(input int which, input string name);
        bit ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if ((which == 0 && pmem_write) || (which == 1 && pmem_read) ||
                (which == 2 && mem_resp) || (which == 3 && pmem_resp)) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
            #1;
        end
        if (!ok) check(name, 32'd0, 32'd1);
    endtask

    task automatic read2(input logic [31:0] addr, output logic [31:0] rd);
        int cyc = 0;
        @(negedge clk);
        m2_address = addr;
        m2_read = 1'b1;
        #1;
        while (!m2_resp && cyc < 50) begin
            @(negedge clk);
            #1;
            cyc++;
        end
        if (!m2_resp) check("w2_timeout", 32'(cyc), 32'd0);
        rd = m2_rdata;
        @(posedge clk);
        #1;
        m2_read = 1'b0;
    endtask

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        int          exp_cyc;
        logic [31:0] exp_hits;
        logic [31:0] exp_miss;
    } vec_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] exp_miss;
    } vec2_t;

    initial begin
        vec_t         tbl [9];
        vec2_t        tbl2 [6];
        logic [31:0]  rd;
        logic [31:0]  hc_snap;
        logic [255:0] l;
        int           cyc;
        int           n_resp;
        bit           bad;

        reset = 1'b1;
        mem_address = 0; mem_read = 0; mem_write = 0; mem_byte_enable = 0; mem_wdata = 0;
        pmem_rdata = 0; pmem_resp = 0;
        m2_address = 0; m2_read = 0; m2_write = 0; m2_be = 0; m2_wdata = 0;
        p2_rdata = 0; p2_resp = 0;

        l = pat_line(32'h40);
        l[31:0] = 32'h1111_1111;
        l[63:32] = 32'h2222_2222;
        pmem_mem[32'h40] = l;

        tbl[0] = '{1'b1, 32'h044, 4'b0011, 32'hDEAD_BEEF, 32'h0,         0, 32'd1, 32'd1};
        tbl[1] = '{1'b0, 32'h044, 4'b0000, 32'h0,         32'h2222_BEEF, 0, 32'd2, 32'd1};
        tbl[2] = '{1'b0, 32'h140, 4'b0000, 32'h0,         32'h5A5A_0140, 4, 32'd2, 32'd2};
        tbl[3] = '{1'b0, 32'h240, 4'b0000, 32'h0,         32'h5A5A_0240, 4, 32'd2, 32'd3};
        tbl[4] = '{1'b0, 32'h340, 4'b0000, 32'h0,         32'h5A5A_0340, 4, 32'd2, 32'd4};
        tbl[5] = '{1'b0, 32'h040, 4'b0000, 32'h0,         32'h1111_1111, 0, 32'd3, 32'd4};
        tbl[6] = '{1'b0, 32'h144, 4'b0000, 32'h0,         32'h5A5A_0144, 0, 32'd4, 32'd4};
        tbl[7] = '{1'b0, 32'h248, 4'b0000, 32'h0,         32'h5A5A_0248, 0, 32'd5, 32'd4};
        tbl[8] = '{1'b0, 32'h34C, 4'b0000, 32'h0,         32'h5A5A_034C, 0, 32'd6, 32'd4};

        tbl2[0] = '{32'h020, 32'd1};
        tbl2[1] = '{32'h120, 32'd2};
        tbl2[2] = '{32'h020, 32'd2};
        tbl2[3] = '{32'h220, 32'd3};
        tbl2[4] = '{32'h020, 32'd3};
        tbl2[5] = '{32'h120, 32'd4};

        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("rst_mem_resp", 32'(mem_resp), 32'd0);
        check("rst_stall", 32'(stall), 32'd0);
        check("rst_pmem_rw", {30'd0, pmem_read, pmem_write}, 32'd0);
        check("rst_pmem_address", pmem_address, 32'd0);
        check("rst_hit_count", hit_count, 32'd0);
        check("rst_miss_count", miss_count, 32'd0);

        // First read: clean miss, fill, retry hit one cycle after pmem_resp
        d1_delay = 3;
        @(negedge clk);
        mem_address = 32'h40;
        mem_read = 1'b1;
        #1;
        wait_for(1, "fill0_wait");
        check("fill0_address", pmem_address, 32'h40);
        check("fill0_miss_count", miss_count, 32'd1);
        wait_for(3, "fill0_resp_wait");
        @(negedge clk);
        #1;
        check("fill0_mem_resp", 32'(mem_resp), 32'd1);
        check("fill0_rdata", mem_rdata, 32'h1111_1111);
        @(posedge clk);
        #1;
        mem_read = 1'b0;
        check("fill0_hit_count", hit_count, 32'd0);

        foreach (tbl[i]) begin
            access(tbl[i].wr, 1'b0, tbl[i].addr, tbl[i].be, tbl[i].wdata, rd, cyc);
            if (!tbl[i].wr) check($sformatf("tbl%0d_rdata", i), rd, tbl[i].exp_rd);
            check($sformatf("tbl%0d_latency", i), 32'(cyc), 32'(tbl[i].exp_cyc));
            check($sformatf("tbl%0d_hits", i), hit_count, tbl[i].exp_hits);
            check($sformatf("tbl%0d_misses", i), miss_count, tbl[i].exp_miss);
        end

        // PLRU eviction of the dirty way 0 line
        @(negedge clk);
        mem_address = 32'h440;
        mem_read = 1'b1;
        #1;
        wait_for(0, "wb_wait");
        check("wb_address", pmem_address, 32'h40);
        check("wb_word1", pmem_wdata[63:32], 32'h2222_BEEF);
        check("wb_no_read", 32'(pmem_read), 32'd0);
        wait_for(1, "evict_fill_wait");
        check("evict_fill_address", pmem_address, 32'h440);
        check("evict_no_write", 32'(pmem_write), 32'd0);
        wait_for(2, "evict_resp_wait");
        check("evict_rdata", mem_rdata, 32'h5A5A_0440);
        @(posedge clk);
        #1;
        mem_read = 1'b0;
        l = get_line(32'h40);
        check("wb_stored_word1", l[63:32], 32'h2222_BEEF);

        // Reset in the middle of a fill
        d1_delay = 20;
        @(negedge clk);
        mem_address = 32'h540;
        mem_read = 1'b1;
        #1;
        wait_for(1, "rstfill_wait");
        @(negedge clk);
        reset = 1'b1;
        mem_read = 1'b0;
        @(posedge clk);
        #1;
        check("rstfill_pmem_read", 32'(pmem_read), 32'd0);
        check("rstfill_hits", hit_count, 32'd0);
        check("rstfill_misses", miss_count, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        d1_delay = 3;
        access(1'b0, 1'b0, 32'h40, 4'b0, 32'h0, rd, cyc);
        check("reread_latency", 32'(cyc), 32'd4);
        check("reread_misses", miss_count, 32'd1);
        check("reread_rdata", rd, 32'h1111_1111);

        // Long pmem latency: CPU sees stall only
        d1_delay = 10;
        hc_snap = hit_count;
        bad = 1'b0;
        @(negedge clk);
        mem_address = 32'h640;
        mem_read = 1'b1;
        for (int k = 0; k < 10; k++) begin
            #1;
            if (!stall || mem_resp || mem_rdata != 0 || hit_count != hc_snap) bad = 1'b1;
            if (k >= 1 && pmem_address != 32'h640) bad = 1'b1;
            @(negedge clk);
        end
        check("stall_window_ok", 32'(bad), 32'd0);
        #1;
        wait_for(2, "stall_resp_wait");
        check("stall_rdata", mem_rdata, 32'h5A5A_0640);
        @(posedge clk);
        #1;
        mem_read = 1'b0;
        check("stall_hits", hit_count, hc_snap);

        // Two-way instance: A, B, A, C evicts B, A hits, B misses again
        foreach (tbl2[i]) begin
            read2(tbl2[i].addr, rd);
            l = pat_line(tbl2[i].addr);
            check($sformatf("w2_%0d_rdata", i), rd, l[31:0]);
            check($sformatf("w2_%0d_misses", i), m2_misses, tbl2[i].exp_miss);
        end

        // Randomized traffic against a flat-memory reference
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        ref_words.delete();
        n_resp = 0;
        for (int n = 0; n < 300; n++) begin
            logic [31:0] a, wd, exp;
            logic [3:0]  be;
            bit          wr, both;
            a = (32'($urandom_range(0, 5)) << 8) | (32'($urandom_range(0, 7)) << 5) |
                (32'($urandom_range(0, 7)) << 2);
            wr = 1'($urandom_range(0, 1));
            both = wr && ($urandom_range(0, 3) == 0);
            be = 4'($urandom_range(1, 15));
            wd = $urandom;
            d1_delay = $urandom_range(1, 4);
            exp = ref_read(a);
            access(wr, both, a, be, wd, rd, cyc);
            n_resp++;
            if (wr) begin
                for (int b = 0; b < 4; b++) if (be[b]) exp[b*8 +: 8] = wd[b*8 +: 8];
                ref_words[a] = exp;
            end else begin
                check($sformatf("rand%0d_rdata@%h", n, a), rd, exp);
            end
        end
        check("rand_resp_accounting", hit_count + miss_count, 32'(n_resp));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscomp);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
